// File: rtl/banked_mem_responder.sv
// Four-bank word-addressed memory model: per-bank 4-cycle occupancy, stall on
// bank conflict, err on illegal requests, reads return after two cycles.
module banked_mem_responder #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o,
    output logic              stall_o,
    output logic [3:0]        busy_o,
    output logic              err_o
);

    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam int unsigned WORD_W    = ADDR_W - 1;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic [NUM_BANKS-1:0][1:0] cnt_q, cnt_d;
    logic [NUM_BANKS-1:0]      busy_q, busy_d;
    logic                      s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]         s1_data_q, s1_data_d;
    logic                      s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0]         s2_data_q, s2_data_d;

    logic              req;
    logic              illegal;
    logic              accept;
    logic [WORD_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [1:0]        bank;

    // Request decode: stall/err react in the same cycle as the request
    always_comb begin
        word_idx = addr_i[ADDR_W-1:1];
        mem_idx  = word_idx[IDX_W-1:0];
        bank     = addr_i[2:1];
        req      = rd_i | wr_i;
        illegal  = (rd_i & wr_i) | addr_i[0] | (32'(word_idx) >= MEM_WORDS);
        err_o    = req & illegal;
        stall_o  = req & ~illegal & busy_q[bank];
        accept   = req & ~illegal & ~busy_q[bank];
    end

    // Next state for bank counters and the two-stage read pipeline
    always_comb begin
        cnt_d     = cnt_q;
        busy_d    = '0;
        s1_vld_d  = 1'b0;
        s1_data_d = '0;
        s2_vld_d  = s1_vld_q;
        s2_data_d = s1_vld_q ? s1_data_q : '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (cnt_q[b] != 2'd0) begin
                cnt_d[b] = cnt_q[b] - 2'd1;
            end
            if (accept && (bank == 2'(b))) begin
                cnt_d[b] = 2'd3;
            end
            busy_d[b] = (cnt_d[b] != 2'd0);
        end
        if (accept && rd_i) begin
            s1_vld_d  = 1'b1;
            s1_data_d = mem_q[mem_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            busy_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
        end
    end

    // Array is deliberately not reset; contents survive rst_n
    always_ff @(posedge clk) begin
        if (accept && wr_i && rst_n) begin
            mem_q[mem_idx] <= data_in_i;
        end
    end

    assign data_out_o   = s2_data_q;
    assign data_valid_o = s2_vld_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Self-checking bench: directed scenarios plus random traffic compared each
// cycle against a timestamp-based model of bank occupancy and read returns.
module tb_banked_mem_responder;

    localparam int unsigned MEM_WORDS = 1024;

    logic        clk;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dv;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int tests;
    int fails;
    int cyc;
    int bank_free [4];
    logic [15:0] mem_m  [int];
    logic [15:0] exp_rd [int];

    banked_mem_responder #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_i        (rd),
        .wr_i        (wr),
        .addr_i      (addr),
        .data_in_i   (din),
        .data_out_o  (dout),
        .data_valid_o(dv),
        .stall_o     (stall),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a bank is busy until the cycle stamped at acceptance + 4;
    // read data is scheduled for acceptance cycle + 2.
    task automatic model_check();
        int         widx;
        int         bk;
        logic [3:0] busy_e;
        bit         rq, ill, err_e, stall_e, has_rd;
        logic [15:0] dout_e;
        widx = int'(addr[15:1]);
        bk   = widx % 4;
        for (int b = 0; b < 4; b++) busy_e[b] = rst_n && (bank_free[b] > cyc);
        has_rd = rst_n && exp_rd.exists(cyc);
        dout_e = has_rd ? exp_rd[cyc] : 16'h0000;
        rq      = rd || wr;
        ill     = (rd && wr) || addr[0] || (widx >= int'(MEM_WORDS));
        err_e   = rq && ill;
        stall_e = rq && !ill && busy_e[bk];
        chk("busy", 32'(busy), 32'(busy_e));
        chk("data_valid", 32'(dv), 32'(has_rd));
        chk("data_out", 32'(dout), 32'(dout_e));
        chk("err", 32'(err), 32'(err_e));
        chk("stall", 32'(stall), 32'(stall_e));
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) bank_free[b] = 0;
            exp_rd.delete();
        end else begin
            if (has_rd) exp_rd.delete(cyc);
            if (rq && !ill && !busy_e[bk]) begin
                bank_free[bk] = cyc + 4;
                if (wr) mem_m[widx] = din;
                else    exp_rd[cyc + 2] = mem_m.exists(widx) ? mem_m[widx] : 16'hxxxx;
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit do_rst = 1'b0);
        @(posedge clk);
        cyc++;
        #1;
        rd = r; wr = w; addr = a; din = d;
        if (do_rst) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst_busy", 32'(busy), 32'h0);
            chk("async_rst_dv", 32'(dv), 32'h0);
            chk("async_rst_dout", 32'(dout), 32'h0);
        end
        @(negedge clk);
        model_check();
        if (do_rst) begin
            #2;
            rst_n = 1'b1;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    function automatic logic [15:0] pool_addr(input int idx);
        int w;
        w = (idx < 32) ? idx : (int'(MEM_WORDS) - 36 + idx);
        return 16'(w * 2);
    endfunction

    initial begin
        tests = 0; fails = 0; cyc = 0;
        for (int b = 0; b < 4; b++) bank_free[b] = 0;
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;

        // Reset and idle
        idle();
        idle();
        #2 rst_n = 1'b1;
        repeat (3) idle();
        chk("idle_busy", 32'(busy), 32'h0);

        // Write then read, bank 0
        step(1'b0, 1'b1, 16'h0000, 16'hBEEF);
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk("wr_busy", 32'(busy), 32'h1);
        end
        step(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("rd_busy_free", 32'(busy), 32'h0);
        chk("rd_no_stall", 32'(stall), 32'h0);
        idle();
        chk("rd_dv_c5", 32'(dv), 32'h0);
        idle();
        chk("rd_dv_c6", 32'(dv), 32'h1);
        chk("rd_data_c6", 32'(dout), 32'hBEEF);
        idle();
        chk("rd_dv_c7", 32'(dv), 32'h0);

        // Bank conflict
        step(1'b0, 1'b1, 16'h0010, 16'h5A5A);
        repeat (3) idle();
        for (int i = 0; i <= 4; i++) begin
            step(1'b1, 1'b0, 16'h0010, 16'h0000);
            chk("conflict_stall", 32'(stall), (i >= 1 && i <= 3) ? 32'h1 : 32'h0);
            if (i == 2) begin
                chk("conflict_dv_c2", 32'(dv), 32'h1);
                chk("conflict_data_c2", 32'(dout), 32'h5A5A);
            end
        end
        idle();
        chk("conflict_dv_c5", 32'(dv), 32'h0);
        idle();
        chk("conflict_dv_c6", 32'(dv), 32'h1);
        chk("conflict_data_c6", 32'(dout), 32'h5A5A);
        repeat (3) idle();

        // Interleave across the four banks
        step(1'b0, 1'b1, 16'h0020, 16'h1111);
        step(1'b0, 1'b1, 16'h0022, 16'h2222);
        step(1'b0, 1'b1, 16'h0024, 16'h3333);
        step(1'b0, 1'b1, 16'h0026, 16'h4444);
        repeat (3) idle();
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, 16'(16'h0020 + j * 2), 16'h0000);
            chk("ilv_stall", 32'(stall), 32'h0);
            if (j == 2) chk("ilv_data0", 32'(dout), 32'h1111);
            if (j == 3) chk("ilv_data1", 32'(dout), 32'h2222);
        end
        idle();
        chk("ilv_data2", 32'(dout), 32'h3333);
        idle();
        chk("ilv_data3", 32'(dout), 32'h4444);
        chk("ilv_dv3", 32'(dv), 32'h1);
        repeat (3) idle();

        // Illegal requests
        step(1'b1, 1'b1, 16'h0000, 16'h0000);
        chk("err_rdwr", 32'({err, stall, busy}), 32'h20);
        step(1'b1, 1'b0, 16'h0001, 16'h0000);
        chk("err_odd", 32'({err, stall, busy}), 32'h20);
        step(1'b1, 1'b0, 16'h0800, 16'h0000);
        chk("err_range", 32'({err, stall, busy}), 32'h20);
        repeat (3) idle();
        chk("err_no_dv", 32'(dv), 32'h0);

        // Reset mid-read
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        idle();
        chk("rstrd_dv", 32'(dv), 32'h0);
        chk("rstrd_busy", 32'(busy), 32'h0);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        chk("rstrd_accept", 32'(stall), 32'h0);
        idle();
        idle();
        chk("rstrd_dv_after", 32'(dv), 32'h1);
        chk("rstrd_data_after", 32'(dout), 32'h1111);
        repeat (2) idle();

        // Fill the random address pool (consecutive words rotate banks)
        for (int p = 0; p < 36; p++) step(1'b0, 1'b1, pool_addr(p), 16'($urandom));

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 10) begin
                idle();
            end else if (r < 16) begin
                case ($urandom_range(0, 2))
                    0:       step(1'b1, 1'b1, pool_addr(int'($urandom_range(0, 35))), 16'($urandom));
                    1:       step($urandom_range(0, 1) == 1, 1'b0, pool_addr(int'($urandom_range(0, 35))) | 16'h1, 16'($urandom));
                    default: step(1'b0, 1'b1, 16'($urandom_range(MEM_WORDS, 32767) * 2), 16'($urandom));
                endcase
            end else begin
                if ($urandom_range(0, 1) == 1)
                    step(1'b1, 1'b0, pool_addr(int'($urandom_range(0, 35))), 16'h0000);
                else
                    step(1'b0, 1'b1, pool_addr(int'($urandom_range(0, 35))), 16'($urandom));
            end
        end
        repeat (4) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/banked_mem_responder.md
# banked_mem_responder

Four-bank, word-addressed memory model that responds to the cache controller's memory-side requests (`rd`/`wr`). It is the far end of the cache-to-memory interface. Each bank is occupied for four cycles per accepted access and reports occupancy on `busy[3:0]`. Conflicting requests are refused with `stall`. Read data returns with a fixed two-cycle latency. The block replaces the behavioural memory stub under the cache so the controller's multi-cycle writeback and fill sequences can be exercised against cycle-accurate bank timing.

## Interface

Parameters:
- `ADDR_W`, default 16: byte address width. `addr[0]` is the byte offset and must be 0.
- `DATA_W`, default 16: word width.
- `MEM_WORDS`, default 1024: total words across all banks. Must be a power of two and ≥ 4.

Ports:
- `clk`, in, 1: single clock. All state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rd`, in, 1: read request this cycle.
- `wr`, in, 1: write request this cycle.
- `addr`, in, `ADDR_W`: byte address. Bank is `addr[2:1]`; word index is `addr[ADDR_W-1:1]`.
- `data_in`, in, `DATA_W`: write data, sampled with `wr`.
- `data_out`, out, `DATA_W`: read data. Forced to 0 whenever `data_valid` is 0.
- `data_valid`, out, 1: one-cycle pulse marking `data_out` valid.
- `stall`, out, 1: request refused because its bank is busy. Combinational.
- `busy`, out, 4: per-bank occupancy. Registered.
- `err`, out, 1: request refused as illegal. Combinational.

## Operation

- Request present: `rd | wr`.
- Illegal request, in priority order. Any of the following asserts `err` and the request is dropped, with no state change:
  - `rd & wr` both high;
  - `addr[0]=1`;
  - word index ≥ `MEM_WORDS`.
- `stall = req & ~err & busy[bank]`. A stalled request is dropped; the requester must hold and retry.
- Accepted when `req & ~err & ~busy[bank]`. On acceptance:
  - the bank counter loads 3;
  - a write commits `data_in` to the array at this edge;
  - a read captures the array word into latency stage 1.
- Per-bank 2-bit down-counter. `busy[b] = (cnt[b] != 0)`. The counter decrements each cycle while nonzero.
- Read pipeline is two stages, each holding a valid bit and data.
  - Stage 2 drives `data_out` and `data_valid`.
  - Multiple banks may have reads in flight at once. Accepted reads are at least one cycle apart, so each stage holds at most one read.
- Array contents are not reset. Reading a never-written word returns X in simulation; the bench writes before reading.
- Reset (asynchronous, `rst_n=0`):
  - `busy=0`, all counters 0;
  - both pipeline stages invalid, so `data_valid=0` and `data_out=0`;
  - `stall` and `err` follow their equations (0 with idle inputs);
  - array contents retained.
- Reset mid-operation: in-flight reads are discarded and never return. A write already accepted before reset stays committed.

## Timing

- Request accepted in cycle N:
  - `busy[bank]=1` in cycles N+1, N+2, N+3; `busy[bank]=0` in N+4;
  - a new request to the same bank is stalled in N+1..N+3 and accepted in N+4;
  - read data appears with `data_valid=1` in cycle N+2 only.
- Different banks are independent. Requests to banks 0, 1, 2, 3 in consecutive cycles N..N+3 are all accepted, and their read data returns in N+2..N+5.
- Bank 0 is free again in N+4. A full four-bank sweep sustains one access per cycle.
- A write followed by a read to the same address is separated by at least four cycles by the bank rule, so the read always sees the written data. No bypass is needed.
- `stall` and `err` are valid in the same cycle as the request. They depend only on the current inputs and the registered `busy`.

## Test plan

- **Reset and idle:** assert `rst_n=0` asynchronously mid-cycle → `busy=0000`, `data_valid=0`, `data_out=0` immediately. Release with no requests → all outputs stay 0.
- **Write then read, bank 0:**
  - `wr` at `addr=0x0000`, `data_in=0xBEEF` in cycle 0 → `busy=0001` for cycles 1–3.
  - `rd` at 0x0000 in cycle 4 → `data_valid=1`, `data_out=0xBEEF` in cycle 6 only.
- **Bank conflict:**
  - `rd` at 0x0010 (bank 0) in cycle 0, then repeat the same `rd` every cycle → `stall=1` in cycles 1–3, accepted in cycle 4 (`stall=0`).
  - Results: `data_valid` pulses in cycles 2 and 6.
- **Interleave:**
  - Pre-write 0x1111, 0x2222, 0x3333, 0x4444 to addresses 0x0020, 0x0022, 0x0024, 0x0026.
  - Read the four in consecutive cycles → no stall. `data_out` returns 0x1111, 0x2222, 0x3333, 0x4444 in four consecutive cycles.
- **Errors:** each of the following gives `err=1`, `stall=0`, `busy` unchanged, and no later `data_valid`:
  - `rd & wr` together;
  - `rd` at 0x0001;
  - `rd` at word index `MEM_WORDS` (0x0800 with defaults).
- **Reset mid-read:** `rd` accepted in cycle 0, `rst_n` low during cycle 1 → no `data_valid` in cycle 2, `busy=0000`. A read of the same address after release returns the stored value.
